// File: rtl/rfid_pio_bidir_if.sv
// Purpose: Avalon-MM slave register-bus bundle for the rfid_pio_bidir GPIO block.
// Latency: writes land on the clk edge of the strobe; readdata is combinational.
// Backpressure: none, the slave is always ready (no waitrequest).
// Ports: address[2:0], chipselect, write_n (active low), writedata[31:0] -> slave;
//        readdata[31:0] -> master.
interface rfid_pio_bidir_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/rfid_pio_bidir.sv
// Purpose: WIDTH-bit bidirectional PIO with direction, set/clear, synchronised inputs, edge capture, irq.
// Latency: register writes visible next cycle; in_port edge reaches edge_cap after SYNC_STAGES+1 edges.
// Backpressure: none, every bus access completes in the cycle it is presented.
// Ports: clk, reset (async, active high), bus (Avalon-MM slave), in_port[WIDTH] pad inputs,
//        out_port[WIDTH] output data register, oe[WIDTH] per-bit output enable, irq level interrupt.
module rfid_pio_bidir #(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] OUT_RESET   = 32'h0,
    parameter logic [31:0] DIR_RESET   = 32'h0,
    parameter int          EDGE_TYPE   = 0,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    rfid_pio_bidir_if.slave  bus,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_DIR    = 3'd1;
    localparam logic [2:0] A_MASK   = 3'd2;
    localparam logic [2:0] A_EDGE   = 3'd3;
    localparam logic [2:0] A_OUTSET = 3'd4;
    localparam logic [2:0] A_OUTCLR = 3'd5;

    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_cap;

    // sync_q[0] is the first (metastable-prone) stage; the last stage is in_sync.
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] in_prev;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] wdat;
    logic [WIDTH-1:0] rd;
    logic             wr;
    logic             unused_ok;

    assign wr      = bus.chipselect & ~bus.write_n;
    assign wdat    = bus.writedata[WIDTH-1:0];
    assign in_sync = sync_q[SYNC_STAGES-1];
    // Upper writedata bits are deliberately ignored when WIDTH < 32.
    assign unused_ok = &{1'b0, bus.writedata};

    // Input synchroniser plus one history stage for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            in_prev <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], in_port};
            in_prev <= in_sync;
        end
    end

    always_comb begin
        edge_det = '0;
        if (EDGE_TYPE == 0) begin
            edge_det = in_sync & ~in_prev;
        end else if (EDGE_TYPE == 1) begin
            edge_det = ~in_sync & in_prev;
        end else begin
            edge_det = in_sync ^ in_prev;
        end
    end

    assign cap_clr = (wr && (bus.address == A_EDGE)) ? wdat : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out <= OUT_RESET[WIDTH-1:0];
            dir      <= DIR_RESET[WIDTH-1:0];
            irq_mask <= '0;
            edge_cap <= '0;
        end else begin
            if (wr) begin
                case (bus.address)
                    A_DATA:   data_out <= wdat;
                    A_DIR:    dir      <= wdat;
                    A_MASK:   irq_mask <= wdat;
                    A_OUTSET: data_out <= data_out | wdat;
                    A_OUTCLR: data_out <= data_out & ~wdat;
                    default:  ;
                endcase
            end
            // Clear first, then OR in new edges so a coincident edge wins.
            edge_cap <= (edge_cap & ~cap_clr) | edge_det;
        end
    end

    always_comb begin
        rd = '0;
        case (bus.address)
            A_DATA:  rd = (data_out & dir) | (in_sync & ~dir);
            A_DIR:   rd = dir;
            A_MASK:  rd = irq_mask;
            A_EDGE:  rd = edge_cap;
            default: rd = '0;
        endcase
        bus.readdata = 32'(rd);
    end

    assign out_port = data_out;
    assign oe       = dir;
    assign irq      = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_rfid_pio_bidir.sv
// Purpose: self-checking bench for rfid_pio_bidir (WIDTH=8, OUT_RESET=A5, DIR_RESET=FF, rising edges).
// Latency: reference model tracks in_port through a history of past samples, SYNC_STAGES deep.
// Backpressure: not applicable; one bus access per clock.
module tb_rfid_pio_bidir;
    localparam int S = 2;

    logic       clk;
    logic       reset;
    logic [7:0] in_port;
    logic [7:0] out_port;
    logic [7:0] oe;
    logic       irq;

    rfid_pio_bidir_if bif ();

    rfid_pio_bidir #(
        .WIDTH(8), .OUT_RESET(32'hA5), .DIR_RESET(32'hFF), .EDGE_TYPE(0), .SYNC_STAGES(S)
    ) dut (
        .clk(clk), .reset(reset), .bus(bif.slave),
        .in_port(in_port), .out_port(out_port), .oe(oe), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: software-visible registers plus the pad values seen
    // at past clock edges (hist[0] = most recent).
    logic [7:0] m_out, m_dir, m_mask, m_cap;
    logic [7:0] hist [0:3];

    function automatic void model_reset();
        m_out  = 8'hA5;
        m_dir  = 8'hFF;
        m_mask = 8'h00;
        m_cap  = 8'h00;
        for (int i = 0; i < 4; i++) hist[i] = 8'h00;
    endfunction

    function automatic void model_edge(input logic [2:0] a, input logic w,
                                       input logic [31:0] d, input logic [7:0] inp);
        logic [7:0] newer, older, ev, clr;
        // The synchronised view lags the pad by S edges; an edge is seen when
        // the two oldest relevant samples differ.
        newer = hist[S-1];
        older = hist[S];
        ev    = newer & ~older;
        clr   = (w && a == 3'd3) ? d[7:0] : 8'h00;
        if (w) begin
            case (a)
                3'd0: m_out  = d[7:0];
                3'd1: m_dir  = d[7:0];
                3'd2: m_mask = d[7:0];
                3'd4: m_out  = m_out | d[7:0];
                3'd5: m_out  = m_out & ~d[7:0];
                default: ;
            endcase
        end
        m_cap = (m_cap & ~clr) | ev;
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = inp;
    endfunction

    function automatic logic [31:0] model_rd(input logic [2:0] a);
        logic [7:0] v;
        case (a)
            3'd0:    v = (m_out & m_dir) | (hist[S-1] & ~m_dir);
            3'd1:    v = m_dir;
            3'd2:    v = m_mask;
            3'd3:    v = m_cap;
            default: v = 8'h00;
        endcase
        return {24'h0, v};
    endfunction

    // One clock: present a bus access and pad value, advance the model, settle.
    task automatic step(input logic [2:0] a, input logic cs, input logic wn,
                        input logic [31:0] d, input logic [7:0] inp);
        bif.address    = a;
        bif.chipselect = cs;
        bif.write_n    = wn;
        bif.writedata  = d;
        in_port        = inp;
        @(posedge clk);
        model_edge(a, cs & ~wn, d, inp);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [7:0] inp);
        step(a, 1'b1, 1'b0, d, inp);
    endtask

    task automatic idle(input logic [2:0] a, input logic [7:0] inp);
        step(a, 1'b0, 1'b1, 32'h0, inp);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bif.address = 3'd0; bif.chipselect = 1'b0; bif.write_n = 1'b1; bif.writedata = 32'h0;
        in_port = 8'h00;
        model_reset();
        #2;
        vectors++; if (out_port !== 8'hA5) begin miscompares++; $display("FAIL reset_out_port got %h want a5", out_port); end
        vectors++; if (oe !== 8'hFF) begin miscompares++; $display("FAIL reset_oe got %h want ff", oe); end
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq got %b want 0", irq); end
        vectors++; if (bif.readdata !== 32'h000000A5) begin miscompares++; $display("FAIL reset_rd_data got %h want 000000a5", bif.readdata); end
        bif.address = 3'd2; #1;
        vectors++; if (bif.readdata !== 32'h0) begin miscompares++; $display("FAIL reset_rd_mask got %h want 0", bif.readdata); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_dir_mux();
        wr(3'd1, 32'h0F, 8'hA0);
        wr(3'd0, 32'h3C, 8'hA0);
        idle(3'd0, 8'hA0);
        idle(3'd0, 8'hA0);
        vectors++; if (bif.readdata !== 32'h000000AC) begin miscompares++; $display("FAIL dir_mux_rd got %h want 000000ac", bif.readdata); end
        vectors++; if (out_port !== 8'h3C) begin miscompares++; $display("FAIL dir_mux_out got %h want 3c", out_port); end
        vectors++; if (oe !== 8'h0F) begin miscompares++; $display("FAIL dir_mux_oe got %h want 0f", oe); end
    endtask

    task automatic test_set_clear();
        wr(3'd0, 32'h00, 8'hA0);
        wr(3'd4, 32'h81, 8'hA0);
        vectors++; if (out_port !== 8'h81) begin miscompares++; $display("FAIL outset got %h want 81", out_port); end
        wr(3'd5, 32'h01, 8'hA0);
        vectors++; if (out_port !== 8'h80) begin miscompares++; $display("FAIL outclr got %h want 80", out_port); end
        wr(3'd4, 32'hFFFFFF00, 8'hA0);
        vectors++; if (out_port !== 8'h80) begin miscompares++; $display("FAIL outset_hi got %h want 80", out_port); end
        vectors++; if (bif.readdata !== 32'h0) begin miscompares++; $display("FAIL rd_outset got %h want 0", bif.readdata); end
    endtask

    task automatic test_edge_irq();
        for (int i = 0; i < 4; i++) idle(3'd3, 8'h00);
        wr(3'd3, 32'hFF, 8'h00);
        idle(3'd3, 8'h00);
        vectors++; if (bif.readdata !== 32'h0) begin miscompares++; $display("FAIL cap_cleared got %h want 0", bif.readdata); end
        wr(3'd2, 32'h02, 8'h00);
        // Pad rises before edge k; capture must appear only after edge k+S.
        idle(3'd3, 8'h02);
        vectors++; if (bif.readdata !== 32'h0) begin miscompares++; $display("FAIL cap_early_k got %h want 0", bif.readdata); end
        idle(3'd3, 8'h02);
        vectors++; if (bif.readdata !== 32'h0) begin miscompares++; $display("FAIL cap_early_k1 got %h want 0", bif.readdata); end
        idle(3'd3, 8'h02);
        vectors++; if (bif.readdata !== 32'h02) begin miscompares++; $display("FAIL cap_rise got %h want 02", bif.readdata); end
        vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_set got %b want 1", irq); end
        wr(3'd3, 32'h02, 8'h02);
        vectors++; if (bif.readdata !== 32'h0) begin miscompares++; $display("FAIL cap_w1c got %h want 0", bif.readdata); end
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_clr got %b want 0", irq); end
        for (int i = 0; i < 3; i++) idle(3'd3, 8'h0A);
        vectors++; if (bif.readdata !== 32'h08) begin miscompares++; $display("FAIL cap_unmasked got %h want 08", bif.readdata); end
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_unmasked got %b want 0", irq); end
    endtask

    task automatic test_collision();
        idle(3'd3, 8'h0B);
        idle(3'd3, 8'h0B);
        wr(3'd3, 32'h01, 8'h0B);
        vectors++; if (bif.readdata !== 32'h09) begin miscompares++; $display("FAIL collision got %h want 09", bif.readdata); end
        wr(3'd3, 32'h01, 8'h0B);
        vectors++; if (bif.readdata !== 32'h08) begin miscompares++; $display("FAIL post_collision_clr got %h want 08", bif.readdata); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) idle(3'd3, 8'h00);
        wr(3'd3, 32'hFF, 8'h00);
        for (int i = 0; i < 3; i++) idle(3'd3, 8'h0F);
        wr(3'd0, 32'h55, 8'h0F);
        wr(3'd2, 32'h0F, 8'h0F);
        bif.address = 3'd3; bif.chipselect = 1'b0; bif.write_n = 1'b1; #1;
        vectors++; if (bif.readdata !== 32'h0F) begin miscompares++; $display("FAIL pre_rst_cap got %h want 0f", bif.readdata); end
        vectors++; if (out_port !== 8'h55) begin miscompares++; $display("FAIL pre_rst_out got %h want 55", out_port); end
        vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL pre_rst_irq got %b want 1", irq); end
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        vectors++; if (out_port !== 8'hA5) begin miscompares++; $display("FAIL mid_rst_out got %h want a5", out_port); end
        vectors++; if (oe !== 8'hFF) begin miscompares++; $display("FAIL mid_rst_oe got %h want ff", oe); end
        vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL mid_rst_irq got %b want 0", irq); end
        vectors++; if (bif.readdata !== 32'h0) begin miscompares++; $display("FAIL mid_rst_cap got %h want 0", bif.readdata); end
        in_port = 8'h00;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idle(3'd3, 8'h00);
            vectors++; if (bif.readdata !== 32'h0) begin miscompares++; $display("FAIL post_rst_cap[%0d] got %h want 0", i, bif.readdata); end
        end
    endtask

    task automatic test_random();
        logic [7:0] inp;
        logic [2:0] a;
        inp = 8'h00;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(3) == 0) inp = 8'($urandom);
            a = 3'($urandom_range(7));
            step(a, 1'($urandom), 1'($urandom), $urandom, inp);
            vectors++; if (bif.readdata !== model_rd(a)) begin miscompares++; $display("FAIL rand_rd[%0d] a=%0d got %h want %h", n, a, bif.readdata, model_rd(a)); end
            vectors++; if (out_port !== m_out) begin miscompares++; $display("FAIL rand_out[%0d] got %h want %h", n, out_port, m_out); end
            vectors++; if (oe !== m_dir) begin miscompares++; $display("FAIL rand_oe[%0d] got %h want %h", n, oe, m_dir); end
            vectors++; if (irq !== |(m_cap & m_mask)) begin miscompares++; $display("FAIL rand_irq[%0d] got %b want %b", n, irq, |(m_cap & m_mask)); end
        end
    endtask

    initial begin
        test_reset();
        test_dir_mux();
        test_set_clear();
        test_edge_irq();
        test_collision();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rfid_pio_bidir.md
Name: rfid_pio_bidir

Overview:
- Parametrised successor to the team's single 8-bit output PIO: a WIDTH-bit general-purpose I/O port on an Avalon-MM slave.
- Adds per-bit direction control, atomic set/clear of output bits, synchronised input sampling, edge capture and a maskable level interrupt.
- Sits between the Nios soft core and RFID front-end control and status lines: TX enable, modulation select, tag-detect and carrier-sense.

Parameters:
- WIDTH, 8, port width in bits; legal range 1..32.
- OUT_RESET, 0, reset value of the output data register (low WIDTH bits used).
- DIR_RESET, 0, reset value of the direction register; 1 = output, 0 = input.
- EDGE_TYPE, 0, edge-capture sensitivity: 0 = rising, 1 = falling, 2 = any.
- SYNC_STAGES, 2, input synchroniser depth; legal range 2..3.

Ports:
- clk, input, 1, system clock; all state is on its rising edge.
- reset, input, 1, asynchronous, active-high reset.
- address, input, 3, register word address.
- chipselect, input, 1, slave select.
- write_n, input, 1, active-low write strobe; a write happens when chipselect=1 and write_n=0.
- writedata, input, 32, write data.
- readdata, output, 32, combinational read data, zero-extended above WIDTH.
- in_port, input, WIDTH, asynchronous pad inputs.
- out_port, output, WIDTH, output data register.
- oe, output, WIDTH, per-bit output enable; equals the direction register.
- irq, output, 1, level interrupt.

Behaviour:
- Register map, all registers WIDTH bits:
  - 0 DATA: write loads data_out; read returns, per bit i, data_out[i] if dir[i]=1, else in_sync[i].
  - 1 DIR: read/write.
  - 2 IRQ_MASK: read/write.
  - 3 EDGE_CAP: read returns captured edges; writing 1 to a bit clears it, writing 0 has no effect.
  - 4 OUTSET: write performs data_out |= writedata; reads 0.
  - 5 OUTCLR: write performs data_out &= ~writedata; reads 0.
  - 6, 7: reserved; writes are ignored, reads return 0.
- readdata is combinational from address and register state, independent of chipselect. Bits 31..WIDTH are always 0. writedata bits above WIDTH are ignored.
- Writes take effect on the clk edge where the write strobe is valid; a readback on the next cycle shows the new value.
- Reset (asynchronous, holds while reset=1):
  - data_out = OUT_RESET, dir = DIR_RESET, irq_mask = 0, edge_cap = 0.
  - All synchroniser and edge-detect flops clear to 0.
  - Resulting outputs: out_port = OUT_RESET, oe = DIR_RESET, irq = 0, readdata as per the map.
- Input path:
  - in_port passes through SYNC_STAGES flops to give in_sync, then one more flop to give in_prev.
  - Edge detect per bit: rise = in_sync & ~in_prev; fall = ~in_sync & in_prev; EDGE_TYPE selects rise, fall or rise|fall.
  - Edge detection runs on every bit, including bits configured as outputs; software masks them out.
  - Latency: an in_port transition that meets setup before edge k shows in in_sync after edge k+SYNC_STAGES-1 and sets edge_cap at edge k+SYNC_STAGES.
- Edge capture:
  - edge_cap[i] is sticky: it sets on a detected edge and holds until cleared by a write-1 to EDGE_CAP.
  - If a clear and a new edge land on the same bit in the same cycle, set wins and the bit stays 1.
  - The first cycle after reset release produces no spurious edge for inputs held at 0. An input already high at release sets the rising capture after the synchroniser fills; this is intended.
- irq = |(edge_cap & irq_mask), registered-source combinational with no extra flop, so it follows edge_cap or mask on the same edge.
- Simultaneous events: only one register is written per cycle (single address), so no write-write conflict exists.
- Reset mid-operation: all state returns to reset values immediately on assertion, independent of clk.

Test Plan:
1. Reset and readback: WIDTH=8, OUT_RESET=8'hA5, DIR_RESET=8'hFF; assert reset → out_port=A5, oe=FF, irq=0; read addr 0 → 0x000000A5, addr 2 → 0.
2. Direction and output mux: write DIR=0x0F, DATA=0x3C; drive in_port=0xA0; after 2 cycles read DATA → 0x000000AC; out_port=0x3C.
3. Set and clear: write DATA=0x00, then OUTSET=0x81 → out_port=0x81; write OUTCLR=0x01 → out_port=0x80; write OUTSET=0xFFFFFF00 → out_port=0x80, bits above WIDTH ignored; read addr 4 → 0.
4. Rising-edge capture and irq:
   - Write IRQ_MASK=0x02; pulse in_port[1] 0→1 → edge_cap=0x02 exactly SYNC_STAGES+1 edges after the change; irq=1.
   - Write EDGE_CAP=0x02 → edge_cap=0, irq=0.
   - An unmasked edge on bit 3 → edge_cap=0x08, irq stays 0.
5. Clear/set collision: time a write EDGE_CAP=0x01 to the same cycle in which a rising edge on bit 0 is detected → edge_cap[0] stays 1.
6. Async reset mid-operation: with edge_cap=0x0F and out_port=0x55, assert reset between clk edges → all outputs reach reset values before the next clk edge; after release no edge is captured for inputs held at 0.
